spike_activity_monitor: RTL

- Downstream consumer of the two-LIF/STDP core's observation outputs: pre spike, post spike and 6-bit synaptic weight.
- Counts spikes per neuron and causal pre→post pairs over a programmable cycle window.
- Computes the signed weight change across each window.
- Presents one result record per window on a valid/ready interface for the readout logic, with an overrun flag when results are lost.

---
 rtl/spike_activity_monitor_if.sv | 22 ++
 rtl/spike_activity_monitor.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/spike_activity_monitor_if.sv
// rtl/spike_activity_monitor_if.sv - result record valid/ready channel of the spike activity monitor
interface spike_activity_monitor_if #(
    parameter int CNT_W = 8
);
    logic             res_valid;
    logic             res_ready;
    logic [CNT_W-1:0] res_pre_cnt;
    logic [CNT_W-1:0] res_post_cnt;
    logic [CNT_W-1:0] res_pair_cnt;
    logic [6:0]       res_wdelta;
    logic             res_sat;

    modport master (
        output res_valid, res_pre_cnt, res_post_cnt, res_pair_cnt, res_wdelta, res_sat,
        input  res_ready
    );

    modport slave (
        input  res_valid, res_pre_cnt, res_post_cnt, res_pair_cnt, res_wdelta, res_sat,
        output res_ready
    );
endinterface

// File: rtl/spike_activity_monitor.sv
// rtl/spike_activity_monitor.sv - windowed spike/pair counter with signed weight delta and single-entry result register
module spike_activity_monitor #(
    parameter int CNT_W    = 8,
    parameter int WIN_W    = 16,
    parameter int PAIR_WIN = 20
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ena,
    input  logic                      clear,
    input  logic                      spike_pre,
    input  logic                      spike_post,
    input  logic [5:0]                weight,
    input  logic [WIN_W-1:0]          win_len,
    spike_activity_monitor_if.master  res,
    output logic                      overrun
);
    localparam int TMR_W = $clog2(PAIR_WIN + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(PAIR_WIN);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [WIN_W-1:0] wcnt;
    logic [CNT_W-1:0] pre_cnt, post_cnt, pair_cnt;
    logic             sat;
    logic [TMR_W-1:0] timer;
    logic [5:0]       w_start;

    logic             is_pair;
    logic [CNT_W-1:0] pre_nxt, post_nxt, pair_nxt;
    logic             sat_nxt;
    logic             win_close;
    logic [6:0]       wdelta;

    // Counts including this cycle's spikes, so close-cycle spikes land in the closing record.
    always_comb begin
        is_pair   = spike_post && (timer != '0);
        pre_nxt   = (spike_pre  && pre_cnt  != CNT_MAX) ? pre_cnt  + 1'b1 : pre_cnt;
        post_nxt  = (spike_post && post_cnt != CNT_MAX) ? post_cnt + 1'b1 : post_cnt;
        pair_nxt  = (is_pair    && pair_cnt != CNT_MAX) ? pair_cnt + 1'b1 : pair_cnt;
        sat_nxt   = sat | (spike_pre  && pre_cnt  == CNT_MAX)
                        | (spike_post && post_cnt == CNT_MAX)
                        | (is_pair    && pair_cnt == CNT_MAX);
        win_close = (wcnt >= win_len - 1'b1);
        wdelta    = {1'b0, weight} - {1'b0, w_start};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            wcnt             <= '0;
            pre_cnt          <= '0;
            post_cnt         <= '0;
            pair_cnt         <= '0;
            sat              <= 1'b0;
            timer            <= '0;
            w_start          <= '0;
            res.res_valid    <= 1'b0;
            res.res_pre_cnt  <= '0;
            res.res_post_cnt <= '0;
            res.res_pair_cnt <= '0;
            res.res_wdelta   <= '0;
            res.res_sat      <= 1'b0;
            overrun          <= 1'b0;
        end else if (clear) begin
            state            <= IDLE;
            wcnt             <= '0;
            pre_cnt          <= '0;
            post_cnt         <= '0;
            pair_cnt         <= '0;
            sat              <= 1'b0;
            timer            <= '0;
            w_start          <= weight;
            res.res_valid    <= 1'b0;
            res.res_pre_cnt  <= '0;
            res.res_post_cnt <= '0;
            res.res_pair_cnt <= '0;
            res.res_wdelta   <= '0;
            res.res_sat      <= 1'b0;
            overrun          <= 1'b0;
        end else begin
            if (res.res_valid && res.res_ready) begin
                res.res_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (ena && win_len != '0) begin
                        state   <= RUN;
                        w_start <= weight;
                        wcnt    <= '0;
                    end
                end
                RUN: begin
                    if (win_len == '0) begin
                        state    <= IDLE;
                        wcnt     <= '0;
                        pre_cnt  <= '0;
                        post_cnt <= '0;
                        pair_cnt <= '0;
                        sat      <= 1'b0;
                        timer    <= '0;
                    end else if (ena) begin
                        if (win_close) begin
                            // A pending unaccepted record wins; the new one is dropped.
                            if (!res.res_valid || res.res_ready) begin
                                res.res_valid    <= 1'b1;
                                res.res_pre_cnt  <= pre_nxt;
                                res.res_post_cnt <= post_nxt;
                                res.res_pair_cnt <= pair_nxt;
                                res.res_wdelta   <= wdelta;
                                res.res_sat      <= sat_nxt;
                            end else begin
                                overrun <= 1'b1;
                            end
                            w_start  <= weight;
                            wcnt     <= '0;
                            pre_cnt  <= '0;
                            post_cnt <= '0;
                            pair_cnt <= '0;
                            sat      <= 1'b0;
                            timer    <= '0;
                        end else begin
                            wcnt     <= wcnt + 1'b1;
                            pre_cnt  <= pre_nxt;
                            post_cnt <= post_nxt;
                            pair_cnt <= pair_nxt;
                            sat      <= sat_nxt;
                            if (spike_pre) begin
                                timer <= TMR_LOAD;
                            end else if (timer != '0) begin
                                timer <= timer - 1'b1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
